// File: rtl/sf_snp_ctrl_if.sv
// ============================================================================
// Module      : sf_snp_ctrl_if
// Description : Bundle for the snoop control stage: POCQ request, snoop
//               filter result, outgoing snoop, incoming SnpResp, completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sf_snp_ctrl_if #(
  parameter int ADDR_W  = 48,
  parameter int STATE_W = 3,
  parameter int RNF_W   = 3,
  parameter int TXNID_W = 12
) ();

  // POCQ request
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic [TXNID_W-1:0]   req_txnid;
  // snoop filter lookup result
  logic                 sf_hit;
  logic [STATE_W-1:0]   sf_hit_state;
  logic [RNF_W-1:0]     sf_owner;
  // outgoing snoop
  logic                 snp_valid;
  logic                 snp_ready;
  logic [ADDR_W-4:0]    snp_addr;
  logic [RNF_W-1:0]     snp_tgtid;
  logic [TXNID_W-1:0]   snp_txnid;
  // incoming snoop response
  logic                 rsp_valid;
  logic [RNF_W-1:0]     rsp_srcid;
  logic [TXNID_W-1:0]   rsp_txnid;
  logic [2:0]           rsp_resp;
  // completion to POCQ
  logic                 done_valid;
  logic                 done_ready;
  logic [TXNID_W-1:0]   done_txnid;
  logic                 done_snooped;
  logic                 done_dirty;
  logic                 done_timeout;

  // environment side (POCQ, filter, snoop network)
  modport master (
    output req_valid, req_addr, req_txnid,
    input  req_ready,
    output sf_hit, sf_hit_state, sf_owner,
    input  snp_valid, snp_addr, snp_tgtid, snp_txnid,
    output snp_ready,
    output rsp_valid, rsp_srcid, rsp_txnid, rsp_resp,
    input  done_valid, done_txnid, done_snooped, done_dirty, done_timeout,
    output done_ready
  );

  // snoop control block side
  modport slave (
    input  req_valid, req_addr, req_txnid,
    output req_ready,
    input  sf_hit, sf_hit_state, sf_owner,
    output snp_valid, snp_addr, snp_tgtid, snp_txnid,
    input  snp_ready,
    input  rsp_valid, rsp_srcid, rsp_txnid, rsp_resp,
    output done_valid, done_txnid, done_snooped, done_dirty, done_timeout,
    input  done_ready
  );

endinterface

`default_nettype wire

// File: rtl/sf_snp_ctrl.sv
// ============================================================================
// Module      : sf_snp_ctrl
// Description : HN-F snoop control stage. Samples the snoop filter result on
//               request accept, issues one snoop to the owning RN-F on a hit,
//               waits (bounded) for the matching SnpResp and reports
//               completion to the POCQ. One transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sf_snp_ctrl #(
  parameter int ADDR_W  = 48,
  parameter int STATE_W = 3,
  parameter int RNF_W   = 3,
  parameter int TXNID_W = 12,
  parameter int TIMEOUT = 1023,
  parameter int SF_I    = 0
) (
  input  wire logic      clock,
  input  wire logic      reset,
  sf_snp_ctrl_if.slave   bus
);

  // The wait counter only has to reach TIMEOUT-1.
  localparam int c_to_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-4:0]    r_addr;
  logic [TXNID_W-1:0]   r_txnid;
  logic [RNF_W-1:0]     r_owner;
  logic [TXNID_W-1:0]   r_snp_cnt;
  logic [TXNID_W-1:0]   r_issued;
  logic [c_to_w-1:0]    r_to_cnt;
  logic                 r_snooped;
  logic                 r_dirty;
  logic                 r_timeout;

  logic                 w_hit;
  logic                 w_match;
  logic                 w_expire;

  // An Invalid state in the filter is a miss even if the hit flag is set.
  assign w_hit    = bus.sf_hit && (bus.sf_hit_state != STATE_W'(SF_I));
  assign w_match  = bus.rsp_valid && (bus.rsp_txnid == r_issued) &&
                    (bus.rsp_srcid == r_owner);
  assign w_expire = (r_to_cnt == c_to_last);

  assign bus.req_ready    = (r_state == S_IDLE);
  assign bus.snp_valid    = (r_state == S_SEND);
  assign bus.snp_addr     = r_addr;
  assign bus.snp_tgtid    = r_owner;
  assign bus.snp_txnid    = r_snp_cnt;
  assign bus.done_valid   = (r_state == S_DONE);
  assign bus.done_txnid   = r_txnid;
  assign bus.done_snooped = r_snooped;
  assign bus.done_dirty   = r_dirty;
  assign bus.done_timeout = r_timeout;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; a match beats expiry in the same WAIT cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.req_valid)           w_state_nxt = w_hit ? S_SEND : S_DONE;
      S_SEND: if (bus.snp_ready)           w_state_nxt = S_WAIT;
      S_WAIT: if (w_match || w_expire)     w_state_nxt = S_DONE;
      S_DONE: if (bus.done_ready)          w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // Captured request, snoop id counter, wait counter and completion flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr    <= '0;
      r_txnid   <= '0;
      r_owner   <= '0;
      r_snp_cnt <= '0;
      r_issued  <= '0;
      r_to_cnt  <= '0;
      r_snooped <= 1'b0;
      r_dirty   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr    <= bus.req_addr[ADDR_W-1:3];
            r_txnid   <= bus.req_txnid;
            r_owner   <= bus.sf_owner;
            r_snooped <= 1'b0;
            r_dirty   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_SEND: begin
          if (bus.snp_ready) begin
            r_issued  <= r_snp_cnt;
            r_snp_cnt <= r_snp_cnt + 1'b1;
            r_to_cnt  <= '0;
          end
        end
        S_WAIT: begin
          if (w_match) begin
            r_snooped <= 1'b1;
            r_dirty   <= bus.rsp_resp[2];
            r_timeout <= 1'b0;
          end else if (w_expire) begin
            r_snooped <= 1'b1;
            r_dirty   <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt  <= r_to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sf_snp_ctrl.sv
// ============================================================================
// Module      : tb_sf_snp_ctrl
// Description : Scoreboard bench for sf_snp_ctrl. Stimulus pushes expected
//               snoops/completions; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sf_snp_ctrl;

  localparam int ADDR_W  = 48;
  localparam int STATE_W = 3;
  localparam int RNF_W   = 3;
  localparam int TXNID_W = 4;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [ADDR_W-4:0]  addr;
    logic [RNF_W-1:0]   tgtid;
    logic [TXNID_W-1:0] txnid;
  } snp_t;

  typedef struct packed {
    logic [TXNID_W-1:0] txnid;
    logic               snooped;
    logic               dirty;
    logic               timeout;
  } done_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sf_snp_ctrl_if #(.ADDR_W(ADDR_W), .STATE_W(STATE_W), .RNF_W(RNF_W),
                   .TXNID_W(TXNID_W)) ifc ();

  sf_snp_ctrl #(.ADDR_W(ADDR_W), .STATE_W(STATE_W), .RNF_W(RNF_W),
                .TXNID_W(TXNID_W), .TIMEOUT(TIMEOUT), .SF_I(0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  int checks   = 0;
  int failures = 0;

  snp_t  exp_snp[$];
  done_t exp_done[$];
  logic [TXNID_W-1:0] snp_id = '0;   // model of the snoop TxnID counter

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Monitor: compare every snoop and completion handshake against the queues.
  snp_t  m_s;
  done_t m_d;
  always @(negedge clock) begin
    if (reset) begin
      if (ifc.snp_valid && ifc.snp_ready) begin
        chk("snp_expected", 64'(exp_snp.size() != 0), 1);
        if (exp_snp.size() != 0) begin
          m_s = exp_snp.pop_front();
          chk("snp_addr",  64'(ifc.snp_addr),  64'(m_s.addr));
          chk("snp_tgtid", 64'(ifc.snp_tgtid), 64'(m_s.tgtid));
          chk("snp_txnid", 64'(ifc.snp_txnid), 64'(m_s.txnid));
        end
      end
      if (ifc.done_valid && ifc.done_ready) begin
        chk("done_expected", 64'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          m_d = exp_done.pop_front();
          chk("done_txnid",   64'(ifc.done_txnid),   64'(m_d.txnid));
          chk("done_snooped", 64'(ifc.done_snooped), 64'(m_d.snooped));
          chk("done_dirty",   64'(ifc.done_dirty),   64'(m_d.dirty));
          chk("done_timeout", 64'(ifc.done_timeout), 64'(m_d.timeout));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one request for exactly its accept cycle; returns at T+1.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [TXNID_W-1:0] t,
                       input logic h, input logic [STATE_W-1:0] st,
                       input logic [RNF_W-1:0] o, input bit exp_hit);
    int n = 0;
    while (!ifc.req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 64'(ifc.req_ready), 1);
    ifc.req_valid    = 1'b1;
    ifc.req_addr     = a;
    ifc.req_txnid    = t;
    ifc.sf_hit       = h;
    ifc.sf_hit_state = st;
    ifc.sf_owner     = o;
    if (exp_hit) begin
      exp_snp.push_back('{addr: ifc.req_addr[ADDR_W-1:3], tgtid: o, txnid: snp_id});
      snp_id++;
    end
    tick();
    ifc.req_valid = 1'b0;
    ifc.sf_hit    = 1'b0;
  endtask

  task automatic respond(input logic [RNF_W-1:0] s, input logic [TXNID_W-1:0] t,
                         input logic [2:0] r);
    ifc.rsp_valid = 1'b1;
    ifc.rsp_srcid = s;
    ifc.rsp_txnid = t;
    ifc.rsp_resp  = r;
    tick();
    ifc.rsp_valid = 1'b0;
  endtask

  logic [TXNID_W-1:0] id;
  logic [RNF_W-1:0]   own;

  initial begin
    ifc.req_valid = 0; ifc.req_addr = '0; ifc.req_txnid = '0;
    ifc.sf_hit = 0; ifc.sf_hit_state = '0; ifc.sf_owner = '0;
    ifc.snp_ready = 1; ifc.rsp_valid = 0; ifc.rsp_srcid = '0;
    ifc.rsp_txnid = '0; ifc.rsp_resp = '0; ifc.done_ready = 1;

    // reset state
    @(negedge clock); @(negedge clock);
    chk("rst_req_ready",  64'(ifc.req_ready), 1);
    chk("rst_snp_valid",  64'(ifc.snp_valid), 0);
    chk("rst_done_valid", 64'(ifc.done_valid), 0);
    @(posedge clock); #1 reset = 1'b1;
    tick();

    // 1: miss
    exp_done.push_back('{txnid: 4'h5, snooped: 0, dirty: 0, timeout: 0});
    issue(48'h0000_1000_0040, 4'h5, 1'b0, 3'd2, 3'd1, 0);
    chk("miss_done_lat",   64'(ifc.done_valid), 1);
    chk("miss_no_snp",     64'(ifc.snp_valid), 0);
    chk("done_req_ready",  64'(ifc.req_ready), 0);
    tick();
    chk("post_done_ready", 64'(ifc.req_ready), 1);

    // 2: hit flag with Invalid state is a miss
    exp_done.push_back('{txnid: 4'h6, snooped: 0, dirty: 0, timeout: 0});
    issue(48'h0000_2000_0080, 4'h6, 1'b1, 3'd0, 3'd3, 0);
    chk("inv_done_lat", 64'(ifc.done_valid), 1);
    chk("inv_no_snp",   64'(ifc.snp_valid), 0);
    tick();

    // 3: hit, snp_ready back-pressure, dirty response, done back-pressure
    ifc.snp_ready = 0;
    exp_done.push_back('{txnid: 4'hA, snooped: 1, dirty: 1, timeout: 0});
    issue(48'h1234_5678_9AB8, 4'hA, 1'b1, 3'd2, 3'd2, 1);
    chk("hit_snp_lat", 64'(ifc.snp_valid), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_snp_valid", 64'(ifc.snp_valid), 1);
      chk("bp_snp_tgtid", 64'(ifc.snp_tgtid), 2);
      chk("bp_snp_txnid", 64'(ifc.snp_txnid), 0);
      chk("bp_snp_addr",  64'(ifc.snp_addr), 64'(48'h1234_5678_9AB8 >> 3));
    end
    ifc.snp_ready = 1;
    tick();
    chk("wait_no_snp", 64'(ifc.snp_valid), 0);
    respond(3'd2, 4'd0, 3'b100);
    chk("rsp_done_lat", 64'(ifc.done_valid), 1);
    ifc.done_ready = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("done_hold_valid", 64'(ifc.done_valid), 1);
      chk("done_hold_dirty", 64'(ifc.done_dirty), 1);
      chk("done_hold_txnid", 64'(ifc.done_txnid), 4'hA);
    end
    ifc.done_ready = 1;
    tick();
    chk("bp_done_ready_back", 64'(ifc.req_ready), 1);

    // 4: stray responses ignored; resp bit2 alone sets dirty
    exp_done.push_back('{txnid: 4'hB, snooped: 1, dirty: 0, timeout: 0});
    id = snp_id;
    issue(48'h0000_0000_0100, 4'hB, 1'b1, 3'd1, 3'd2, 1);
    tick();
    respond(3'd1, id, 3'b100);
    chk("stray_src", 64'(ifc.done_valid), 0);
    respond(3'd2, 4'd7, 3'b100);
    chk("stray_txn", 64'(ifc.done_valid), 0);
    respond(3'd2, id, 3'b011);
    chk("stray_done", 64'(ifc.done_valid), 1);
    tick();

    // 5a: timeout exactly TIMEOUT cycles after the snoop handshake
    exp_done.push_back('{txnid: 4'hC, snooped: 1, dirty: 0, timeout: 1});
    issue(48'h0000_0000_0200, 4'hC, 1'b1, 3'd3, 3'd5, 1);
    tick();
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      chk("to_not_yet", 64'(ifc.done_valid), 0);
    end
    tick();
    chk("to_done",    64'(ifc.done_valid), 1);
    chk("to_flag",    64'(ifc.done_timeout), 1);
    tick();

    // 5b: match in the expiry cycle wins
    exp_done.push_back('{txnid: 4'hD, snooped: 1, dirty: 1, timeout: 0});
    id = snp_id;
    issue(48'h0000_0000_0300, 4'hD, 1'b1, 3'd3, 3'd5, 1);
    tick();
    for (int k = 1; k < TIMEOUT; k++) tick();
    chk("exp_cycle_wait", 64'(ifc.done_valid), 0);
    respond(3'd5, id, 3'b100);
    chk("exp_match_done", 64'(ifc.done_valid), 1);
    chk("exp_match_to",   64'(ifc.done_timeout), 0);
    tick();

    // 6a: run the snoop id through a full wrap
    for (int i = 0; i < (1 << TXNID_W); i++) begin
      id  = snp_id;
      own = RNF_W'(i % 8);
      exp_done.push_back('{txnid: TXNID_W'(i), snooped: 1, dirty: i[0], timeout: 0});
      issue(48'(64'h4000 + 64'(i) * 64), TXNID_W'(i), 1'b1, 3'd1, own, 1);
      if (id == '0) chk("wrap_txnid", 64'(ifc.snp_txnid), 0);
      tick();
      respond(own, id, {i[0], 2'b00});
      tick();
    end

    // 6b: reset during SEND drops the transaction silently
    ifc.snp_ready = 0;
    issue(48'h0000_0000_0500, 4'hE, 1'b1, 3'd2, 3'd4, 1);
    chk("pre_rst_snp", 64'(ifc.snp_valid), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_snp_valid",  64'(ifc.snp_valid), 0);
    chk("mid_rst_req_ready",  64'(ifc.req_ready), 1);
    chk("mid_rst_done_valid", 64'(ifc.done_valid), 0);
    void'(exp_snp.pop_back());
    snp_id = '0;
    ifc.snp_ready = 1;
    @(posedge clock); #1 reset = 1'b1;
    tick();
    exp_done.push_back('{txnid: 4'h3, snooped: 1, dirty: 0, timeout: 0});
    id = snp_id;
    issue(48'h0000_0000_0600, 4'h3, 1'b1, 3'd2, 3'd6, 1);
    chk("post_rst_txnid", 64'(ifc.snp_txnid), 0);
    tick();
    respond(3'd6, id, 3'b000);
    tick();
    tick();

    chk("snp_queue_empty",  64'(exp_snp.size()), 0);
    chk("done_queue_empty", 64'(exp_done.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/sf_snp_ctrl.md
Name: sf_snp_ctrl

Overview:
- Snoop control stage directly downstream of the HN-F snoop filter.
- For each POCQ request it samples the filter's combinational hit/state/owner result in the accept cycle. On a hit, it issues one SnpUnique to the owning RN-F and waits for the matching SnpResp.
- Reports completion (clean, dirty or timed out) back to the POCQ.
- Handles one transaction at a time; the POCQ serialises requests.

Parameters:
- ADDR_W, 48, request/snoop address width
- STATE_W, 3, snoop filter state width (`CHI_CACHE_STATE_W`)
- RNF_W, 3, RN-F node id width
- TXNID_W, 12, CHI TxnID width
- TIMEOUT, 1023, max WAIT cycles before abort; must be ≥1
- SF_I, 0, filter state encoding for Invalid

Ports:
- clock  in  1  single clock, all state on its rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  POCQ request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  request line address
- req_txnid  in  TXNID_W  POCQ transaction id
- sf_hit  in  1  filter hit, valid in the req accept cycle
- sf_hit_state  in  STATE_W  filter line state
- sf_owner  in  RNF_W  RN-F id recorded for the line
- snp_valid  out  1  snoop flit valid
- snp_ready  in  1  snoop channel accepts
- snp_addr  out  ADDR_W-3  snoop address (req_addr[ADDR_W-1:3])
- snp_tgtid  out  RNF_W  target RN-F
- snp_txnid  out  TXNID_W  snoop TxnID
- rsp_valid  in  1  SnpResp flit valid (rsp_ready is implicitly 1)
- rsp_srcid  in  RNF_W  responder id
- rsp_txnid  in  TXNID_W  responder TxnID
- rsp_resp  in  3  Resp field; bit2 is PassDirty
- done_valid  out  1  completion valid
- done_ready  in  1  POCQ accepts completion
- done_txnid  out  TXNID_W  echoed req_txnid
- done_snooped  out  1  a snoop was issued
- done_dirty  out  1  owner passed dirty data
- done_timeout  out  1  WAIT expired without a matching response

Behaviour:
- Reset values (reset==0, asynchronous):
  - state=IDLE; req_ready=1; snp_valid=0; done_valid=0.
  - All captured fields 0; snoop TxnID counter 0; timeout counter 0.
  - Reset mid-operation abandons the transaction silently; no done is produced.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - Accept on req_valid & req_ready; capture addr, txnid, owner.
  - hit = sf_hit & (sf_hit_state != SF_I), sampled in the same cycle.
  - hit → SEND; miss → DONE with snooped=0, dirty=0, timeout=0.
- SEND:
  - snp_valid=1, with addr/tgtid/txnid stable until snp_ready.
  - snp_txnid = current counter value.
  - On handshake: counter += 1 (wraps at 2^TXNID_W), timeout counter cleared, → WAIT.
- WAIT:
  - A response matches when rsp_valid & rsp_txnid==issued snp_txnid & rsp_srcid==owner.
  - Match → DONE with snooped=1, dirty=rsp_resp[2], timeout=0.
  - Non-matching responses are consumed and dropped, with no state change.
  - Otherwise the counter increments each cycle. When counter==TIMEOUT-1 and there is no match this cycle → DONE with snooped=1, dirty=0, timeout=1.
  - A match arriving in the same cycle as expiry wins; timeout=0.
- DONE:
  - done_valid=1; done_* stable until done_ready.
  - On handshake → IDLE; req_ready returns to 1 on the next cycle, so there is no same-cycle accept.
- Latency:
  - Miss: accept at cycle T, done_valid at T+1.
  - Hit with snp_ready=1: snp_valid at T+1; response at the earliest T+2; done_valid at the response cycle +1.
- req_ready=0 in all states except IDLE. The snoop opcode is fixed to SnpUnique outside this block.

Test Plan:
1. Miss: sf_hit=0, req_txnid=0x05 → no snp_valid; done_valid at T+1 with txnid=0x05, snooped=0, dirty=0, timeout=0.
2. Hit, state SF_I: sf_hit=1, sf_hit_state=0 → treated as a miss; same response as scenario 1.
3. Hit, owner=2, snp_ready held 0 for 3 cycles → snp_valid held with tgtid=2, snp_txnid=0 stable. Then rsp(srcid=2, txnid=0, resp=3'b100) → done dirty=1, snooped=1.
4. Stray response: in WAIT, rsp(srcid=1, txnid=0) then rsp(srcid=2, txnid=7) → both ignored, block stays in WAIT. A correct response then completes with dirty=0 for resp=0.
5. Timeout: TIMEOUT=8, no response → done_timeout=1 exactly 8 cycles after the snoop handshake. Also verify a match in the expiry cycle yields timeout=0.
6. TxnID wrap and reset: issue 2^TXNID_W snoops → snp_txnid wraps to 0. Drop reset during SEND → snp_valid=0 and req_ready=1 immediately, with no done.
